// File: rtl/mcu_link_pkg.sv
// Shared codes, field positions and helpers for the MCU<->ROCSTAR link endpoint.
package mcu_link_pkg;

    // MCU->ROCSTAR 4-bit word codes
    localparam logic [3:0] K_IDLE0 = 4'b0111;
    localparam logic [3:0] K_IDLE1 = 4'b1011;
    localparam logic [3:0] K_IDLE2 = 4'b1101;
    localparam logic [3:0] K_IDLE3 = 4'b1110;
    localparam logic [3:0] K_NCOIN = 4'b1001;
    localparam logic [3:0] K_PCOIN = 4'b0011;
    localparam logic [3:0] K_DCOIN = 4'b0110;
    localparam logic [3:0] K_SPECL = 4'b1100;

    // Special-word payloads
    localparam logic [15:0] SPWORD_SYNCH = 16'h1111;
    localparam logic [15:0] SPWORD_START = 16'h2222;
    localparam logic [15:0] SPWORD_END   = 16'h3333;
    localparam logic [15:0] SPWORD_SVCLK = 16'h4444;

    // ROCSTAR->MCU 8-bit word fields
    localparam int RX_SINGLE_BIT = 7;
    localparam int RX_TAG_MSB    = 7;
    localparam int RX_TAG_LSB    = 6;
    localparam int RX_IDX_MSB    = 3;
    localparam int RX_IDX_LSB    = 2;
    localparam logic [1:0] RX_TAG_IDLE = 2'b01;
    localparam logic [1:0] RX_TAG_BAD  = 2'b00;

    typedef enum logic [2:0] {
        TX_IDL,
        TX_SPK,
        TX_SPN3,
        TX_SPN2,
        TX_SPN1,
        TX_SPN0,
        TX_GRD
    } tx_state_t;

    function automatic logic [3:0] idle_word(input logic [1:0] phase);
        case (phase)
            2'd0:    return K_IDLE0;
            2'd1:    return K_IDLE1;
            2'd2:    return K_IDLE2;
            default: return K_IDLE3;
        endcase
    endfunction

    // Unused type code 3 falls back to NCOIN
    function automatic logic [3:0] coin_code(input logic [1:0] ctype);
        case (ctype)
            2'd1:    return K_PCOIN;
            2'd2:    return K_DCOIN;
            default: return K_NCOIN;
        endcase
    endfunction

endpackage

// File: rtl/mcu_link_rx_decode.sv
// RX path: decodes ROCSTAR words into single hits, idle-counter snapshots and error counts.
module mcu_link_rx_decode
    import mcu_link_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       word,
    output logic             single,
    output logic [6:0]       single_ofs,
    output logic [15:0]      idlecnt,
    output logic             link_ok,
    output logic [CNT_W-1:0] badidle,
    output logic [CNT_W-1:0] badword,
    output logic [CNT_W-1:0] numsingl
);

    logic [1:0]  exp_idx;
    logic        chain;     // nibbles 0..exp_idx-1 of the current set arrived in order
    logic [11:0] partial;
    logic [1:0]  idx;
    logic [3:0]  nib;
    logic [1:0]  tag;

    assign idx = word[RX_IDX_MSB:RX_IDX_LSB];
    assign nib = {word[5:4], word[1:0]};
    assign tag = word[RX_TAG_MSB:RX_TAG_LSB];

    // Classify each word, track idle ordering and assemble the idle counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            single     <= 1'b0;
            single_ofs <= '0;
            idlecnt    <= '0;
            link_ok    <= 1'b0;
            badidle    <= '0;
            badword    <= '0;
            numsingl   <= '0;
            exp_idx    <= '0;
            chain      <= 1'b0;
            partial    <= '0;
        end else begin
            single <= 1'b0;
            if (word[RX_SINGLE_BIT]) begin
                single     <= 1'b1;
                single_ofs <= word[6:0];
                numsingl   <= numsingl + CNT_W'(1);
                exp_idx    <= 2'd0;
                chain      <= 1'b0;
            end else if (tag == RX_TAG_IDLE) begin
                exp_idx <= idx + 2'd1;
                if (idx != exp_idx) begin
                    badidle <= badidle + CNT_W'(1);
                    link_ok <= 1'b0;
                    chain   <= 1'b0;
                end else begin
                    case (idx)
                        2'd0: begin
                            partial[3:0] <= nib;
                            chain        <= 1'b1;
                        end
                        2'd1: partial[7:4]  <= nib;
                        2'd2: partial[11:8] <= nib;
                        default: begin
                            chain <= 1'b0;
                            if (chain) begin
                                idlecnt <= {nib, partial};
                                link_ok <= 1'b1;
                            end
                        end
                    endcase
                end
            end else begin
                badword <= badword + CNT_W'(1);
                link_ok <= 1'b0;
                exp_idx <= 2'd0;
                chain   <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/mcu_rocstar_link.sv
// MCU-side endpoint of one MCU<->ROCSTAR port: TX word sequencer plus RX decoder.
//
//  state | meaning
//  IDL   | idles/coin replies; accepts coin or special requests
//  SPK   | K_SPECL on the wire; choosing payload nibble [15:12]
//  SPN3  | choosing payload nibble [11:8]
//  SPN2  | choosing payload nibble [7:4]
//  SPN1  | choosing payload nibble [3:0]
//  SPN0  | last nibble on the wire; choosing first guard idle
//  GRD   | remaining guard idles (only when SP_GUARD > 1)
module mcu_rocstar_link
    import mcu_link_pkg::*;
#(
    parameter int CNT_W    = 16,
    parameter int SP_GUARD = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic [3:0]       to_rocstar,
    input  logic [7:0]       from_rocstar,
    input  logic             coin_valid,
    input  logic [1:0]       coin_type,
    output logic             coin_ready,
    input  logic             sp_valid,
    input  logic [15:0]      sp_word,
    output logic             sp_ready,
    output logic             single,
    output logic [6:0]       single_ofs,
    output logic [15:0]      idlecnt_rx,
    output logic             link_ok,
    output logic [CNT_W-1:0] rx_badidle,
    output logic [CNT_W-1:0] rx_badword,
    output logic [CNT_W-1:0] rx_numsingl,
    output logic [CNT_W-1:0] tx_numcoin
);

    tx_state_t   state, state_nxt;
    logic [1:0]  idle_ph, idle_ph_nxt;
    logic [15:0] sp_data;
    logic [7:0]  guard_cnt, guard_nxt;
    logic [3:0]  word_nxt;
    logic        idle_send;

    // Next-word selection; ready is held low while reset is asserted
    always_comb begin
        state_nxt  = state;
        guard_nxt  = guard_cnt;
        word_nxt   = K_IDLE0;
        idle_send  = 1'b0;
        coin_ready = 1'b0;
        sp_ready   = 1'b0;
        case (state)
            TX_IDL: begin
                coin_ready = rst_n;
                sp_ready   = rst_n && !coin_valid;
                if (coin_valid) begin
                    word_nxt = coin_code(coin_type);
                end else if (sp_valid) begin
                    word_nxt  = K_SPECL;
                    state_nxt = TX_SPK;
                end else begin
                    idle_send = 1'b1;
                end
            end
            TX_SPK: begin
                word_nxt  = sp_data[15:12];
                state_nxt = TX_SPN3;
            end
            TX_SPN3: begin
                word_nxt  = sp_data[11:8];
                state_nxt = TX_SPN2;
            end
            TX_SPN2: begin
                word_nxt  = sp_data[7:4];
                state_nxt = TX_SPN1;
            end
            TX_SPN1: begin
                word_nxt  = sp_data[3:0];
                state_nxt = TX_SPN0;
            end
            TX_SPN0: begin
                idle_send = 1'b1;
                if (SP_GUARD > 1) begin
                    state_nxt = TX_GRD;
                    guard_nxt = 8'(SP_GUARD - 1);
                end else begin
                    state_nxt = TX_IDL;
                end
            end
            TX_GRD: begin
                idle_send = 1'b1;
                guard_nxt = guard_cnt - 8'd1;
                if (guard_cnt == 8'd1) state_nxt = TX_IDL;
            end
            default: state_nxt = TX_IDL;
        endcase
        if (idle_send) word_nxt = idle_word(idle_ph);
        idle_ph_nxt = idle_send ? idle_ph + 2'd1 : 2'd0;
    end

    // TX state, registered word and coincidence count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= TX_IDL;
            to_rocstar <= K_IDLE3;
            idle_ph    <= 2'd0;
            sp_data    <= '0;
            guard_cnt  <= '0;
            tx_numcoin <= '0;
        end else begin
            state      <= state_nxt;
            to_rocstar <= word_nxt;
            idle_ph    <= idle_ph_nxt;
            guard_cnt  <= guard_nxt;
            if (sp_valid && sp_ready) sp_data <= sp_word;
            if (coin_valid && coin_ready) tx_numcoin <= tx_numcoin + CNT_W'(1);
        end
    end

    mcu_link_rx_decode #(.CNT_W(CNT_W)) u_rx (
        .clk        (clk),
        .rst_n      (rst_n),
        .word       (from_rocstar),
        .single     (single),
        .single_ofs (single_ofs),
        .idlecnt    (idlecnt_rx),
        .link_ok    (link_ok),
        .badidle    (rx_badidle),
        .badword    (rx_badword),
        .numsingl   (rx_numsingl)
    );

endmodule

// File: tb/tb_mcu_rocstar_link.sv
// Bench for mcu_rocstar_link: directed link scenarios plus random traffic against a queue/history model.
module tb_mcu_rocstar_link;

    localparam int CNT_W    = 16;
    localparam int SP_GUARD = 1;
    localparam logic [3:0] IDLE_TBL [4] = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [3:0]       to_rocstar;
    logic [7:0]       from_rocstar = 8'h80;
    logic             coin_valid = 1'b0;
    logic [1:0]       coin_type = 2'd0;
    logic             coin_ready;
    logic             sp_valid = 1'b0;
    logic [15:0]      sp_word = 16'h0;
    logic             sp_ready;
    logic             single;
    logic [6:0]       single_ofs;
    logic [15:0]      idlecnt_rx;
    logic             link_ok;
    logic [CNT_W-1:0] rx_badidle, rx_badword, rx_numsingl, tx_numcoin;

    always #5 clk = ~clk;

    mcu_rocstar_link #(.CNT_W(CNT_W), .SP_GUARD(SP_GUARD)) dut (
        .clk(clk), .rst_n(rst_n), .to_rocstar(to_rocstar), .from_rocstar(from_rocstar),
        .coin_valid(coin_valid), .coin_type(coin_type), .coin_ready(coin_ready),
        .sp_valid(sp_valid), .sp_word(sp_word), .sp_ready(sp_ready),
        .single(single), .single_ofs(single_ofs), .idlecnt_rx(idlecnt_rx), .link_ok(link_ok),
        .rx_badidle(rx_badidle), .rx_badword(rx_badword), .rx_numsingl(rx_numsingl),
        .tx_numcoin(tx_numcoin)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [4:0]  tx_q [$];   // bit4 set = guard idle, else literal word
    int          ph;
    int          numcoin_e, nsing_e, badi_e, badw_e;
    logic        single_e, link_e;
    logic [6:0]  ofs_e;
    logic [15:0] idlecnt_e;
    logic [7:0]  hist [4];   // last four RX words, hist[3] newest
    logic        coin_acc, sp_acc;

    // ROCSTAR stream generator
    logic [15:0] roc_cnt;
    int          roc_ph;

    // Pending requests
    logic        cp, spp;
    logic [1:0]  ctp;
    logic [15:0] swp;
    logic [7:0]  rxw;

    logic [3:0] t1_exp [8] = '{4'h7, 4'hB, 4'hD, 4'hE, 4'h7, 4'hB, 4'hD, 4'hE};
    logic [3:0] t3_exp [7] = '{4'hC, 4'h2, 4'h2, 4'h2, 4'h2, 4'h7, 4'h9};
    logic [3:0] t4_exp [7] = '{4'h3, 4'hC, 4'h1, 4'h1, 4'h1, 4'h1, 4'h7};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] nib(input logic [7:0] w);
        return {w[5:4], w[1:0]};
    endfunction

    function automatic logic [31:0] cmask(input int v);
        return 32'(v & ((1 << CNT_W) - 1));
    endfunction

    task automatic model_reset();
        tx_q.delete();
        ph = 0;
        numcoin_e = 0; nsing_e = 0; badi_e = 0; badw_e = 0;
        single_e = 1'b0; link_e = 1'b0; ofs_e = '0; idlecnt_e = '0;
        for (int i = 0; i < 4; i++) hist[i] = 8'h80;
        cp = 1'b0; spp = 1'b0; ctp = 2'd0; swp = 16'h0;
    endtask

    task automatic next_idle(output logic [3:0] w);
        w = IDLE_TBL[ph];
        ph = (ph + 1) % 4;
    endtask

    task automatic roc_word(output logic [7:0] w);
        logic [3:0] n;
        n = roc_cnt[roc_ph*4 +: 4];
        w = {2'b01, n[3:2], 2'(roc_ph), n[1:0]};
        if (roc_ph == 3) begin
            roc_ph = 0;
            roc_cnt = 16'($urandom);
        end else begin
            roc_ph++;
        end
    endtask

    task automatic gen_rx(output logic [7:0] w);
        int r;
        r = int'($urandom_range(0, 99));
        if (r < 70) roc_word(w);
        else if (r < 85) begin
            w = {1'b1, 7'($urandom)};
            roc_ph = 0;
        end
        else if (r < 95) w = {2'b01, 6'($urandom)};
        else w = {2'b00, 6'($urandom)};
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_to_rocstar"}, 32'(to_rocstar), 32'h0000000E);
        chk({tag, "_coin_ready"}, 32'(coin_ready), 32'h0);
        chk({tag, "_sp_ready"}, 32'(sp_ready), 32'h0);
        chk({tag, "_single"}, 32'(single), 32'h0);
        chk({tag, "_single_ofs"}, 32'(single_ofs), 32'h0);
        chk({tag, "_idlecnt"}, 32'(idlecnt_rx), 32'h0);
        chk({tag, "_link_ok"}, 32'(link_ok), 32'h0);
        chk({tag, "_badidle"}, 32'(rx_badidle), 32'h0);
        chk({tag, "_badword"}, 32'(rx_badword), 32'h0);
        chk({tag, "_numsingl"}, 32'(rx_numsingl), 32'h0);
        chk({tag, "_numcoin"}, 32'(tx_numcoin), 32'h0);
    endtask

    // One clock: apply inputs, check handshake, advance model, check registered outputs
    task automatic step(input logic cv, input logic [1:0] ct, input logic sv,
                        input logic [15:0] sw, input logic [7:0] rx);
        logic [3:0] w_exp;
        logic       busy;
        logic [4:0] e;
        logic [1:0] pe;
        coin_valid = cv; coin_type = ct; sp_valid = sv; sp_word = sw; from_rocstar = rx;
        #1;
        busy = (tx_q.size() != 0);
        chk("coin_ready", 32'(coin_ready), 32'(!busy));
        chk("sp_ready", 32'(sp_ready), 32'(!busy && !cv));
        coin_acc = 1'b0; sp_acc = 1'b0;
        w_exp = 4'h0;
        if (busy) begin
            e = tx_q.pop_front();
            if (e[4]) next_idle(w_exp);
            else begin
                w_exp = e[3:0];
                ph = 0;
            end
        end else if (cv) begin
            coin_acc = 1'b1;
            numcoin_e++;
            ph = 0;
            w_exp = (ct == 2'd1) ? 4'b0011 : (ct == 2'd2) ? 4'b0110 : 4'b1001;
        end else if (sv) begin
            sp_acc = 1'b1;
            ph = 0;
            w_exp = 4'b1100;
            tx_q.push_back({1'b0, sw[15:12]});
            tx_q.push_back({1'b0, sw[11:8]});
            tx_q.push_back({1'b0, sw[7:4]});
            tx_q.push_back({1'b0, sw[3:0]});
            for (int g = 0; g < SP_GUARD; g++) tx_q.push_back(5'h10);
        end else begin
            next_idle(w_exp);
        end

        single_e = 1'b0;
        if (rx[7]) begin
            single_e = 1'b1;
            ofs_e = rx[6:0];
            nsing_e++;
        end else if (rx[7:6] == 2'b00) begin
            badw_e++;
            link_e = 1'b0;
        end else begin
            pe = (hist[3][7:6] == 2'b01) ? hist[3][3:2] + 2'd1 : 2'd0;
            if (rx[3:2] != pe) begin
                badi_e++;
                link_e = 1'b0;
            end else if (rx[3:2] == 2'd3 &&
                         hist[2][7:6] == 2'b01 && hist[2][3:2] == 2'd1 &&
                         hist[1][7:6] == 2'b01 && hist[1][3:2] == 2'd0 &&
                         (hist[0][7:6] != 2'b01 || hist[0][3:2] == 2'd3)) begin
                idlecnt_e = {nib(rx), nib(hist[3]), nib(hist[2]), nib(hist[1])};
                link_e = 1'b1;
            end
        end
        hist[0] = hist[1]; hist[1] = hist[2]; hist[2] = hist[3]; hist[3] = rx;

        @(posedge clk);
        #1;
        chk("to_rocstar", 32'(to_rocstar), 32'(w_exp));
        chk("single", 32'(single), 32'(single_e));
        chk("single_ofs", 32'(single_ofs), 32'(ofs_e));
        chk("idlecnt_rx", 32'(idlecnt_rx), 32'(idlecnt_e));
        chk("link_ok", 32'(link_ok), 32'(link_e));
        chk("rx_badidle", 32'(rx_badidle), cmask(badi_e));
        chk("rx_badword", 32'(rx_badword), cmask(badw_e));
        chk("rx_numsingl", 32'(rx_numsingl), cmask(nsing_e));
        chk("tx_numcoin", 32'(tx_numcoin), cmask(numcoin_e));
    endtask

    initial begin
        model_reset();
        roc_cnt = 16'hA5C3;
        roc_ph = 0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;

        // Idle cycle after reset with an idlecnt=A5C3 ROCSTAR set looped in
        for (int i = 0; i < 8; i++) begin
            roc_word(rxw);
            step(1'b0, 2'd0, 1'b0, 16'h0, rxw);
            chk("t1_idle_seq", 32'(to_rocstar), 32'(t1_exp[i]));
            if (i == 3) begin
                chk("t2_idlecnt", 32'(idlecnt_rx), 32'h0000A5C3);
                chk("t2_link_ok", 32'(link_ok), 32'h1);
                chk("t2_badidle", 32'(rx_badidle), 32'h0);
            end
        end

        // START special, coin raised mid-sequence waits for the guard
        spp = 1'b1; swp = 16'h2222;
        for (int i = 0; i < 7; i++) begin
            if (i == 1) begin cp = 1'b1; ctp = 2'd0; end
            roc_word(rxw);
            step(cp, ctp, spp, swp, rxw);
            if (coin_acc) cp = 1'b0;
            if (sp_acc) spp = 1'b0;
            chk("t3_word", 32'(to_rocstar), 32'(t3_exp[i]));
        end

        // Coin and special together: coin first
        cp = 1'b1; ctp = 2'd1; spp = 1'b1; swp = 16'h1111;
        for (int i = 0; i < 7; i++) begin
            roc_word(rxw);
            step(cp, ctp, spp, swp, rxw);
            if (coin_acc) cp = 1'b0;
            if (sp_acc) spp = 1'b0;
            chk("t4_word", 32'(to_rocstar), 32'(t4_exp[i]));
        end

        // Single, out-of-order idle, bad word
        step(1'b0, 2'd0, 1'b0, 16'h0, 8'hC5);
        chk("t5_single", 32'(single), 32'h1);
        chk("t5_single_ofs", 32'(single_ofs), 32'h45);
        step(1'b0, 2'd0, 1'b0, 16'h0, 8'h48);
        chk("t5_badidle", 32'(rx_badidle), 32'h1);
        step(1'b0, 2'd0, 1'b0, 16'h0, 8'h00);
        chk("t5_badword", 32'(rx_badword), 32'h1);
        chk("t5_link_ok", 32'(link_ok), 32'h0);
        roc_ph = 0;

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            if (!cp && $urandom_range(0, 5) == 0) begin
                cp = 1'b1;
                ctp = 2'($urandom_range(0, 3));
            end
            if (!spp && $urandom_range(0, 7) == 0) begin
                spp = 1'b1;
                swp = 16'($urandom);
            end
            gen_rx(rxw);
            step(cp, ctp, spp, swp, rxw);
            if (coin_acc) cp = 1'b0;
            if (sp_acc) spp = 1'b0;
        end

        // Reset in the middle of a special word
        cp = 1'b0; spp = 1'b0;
        while (tx_q.size() != 0) begin
            roc_word(rxw);
            step(1'b0, 2'd0, 1'b0, 16'h0, rxw);
        end
        step(1'b0, 2'd0, 1'b1, 16'h5A3C, 8'h80);
        step(1'b0, 2'd0, 1'b0, 16'h0, 8'h80);
        step(1'b0, 2'd0, 1'b0, 16'h0, 8'h80);
        rst_n = 1'b0;
        coin_valid = 1'b0; sp_valid = 1'b0; from_rocstar = 8'h80;
        #1;
        check_reset_outputs("t6");
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        roc_ph = 0;
        step(1'b0, 2'd0, 1'b0, 16'h0, 8'h80);
        chk("t6_first_idle", 32'(to_rocstar), 32'h7);

        for (int n = 0; n < 300; n++) begin
            if (!cp && $urandom_range(0, 4) == 0) begin
                cp = 1'b1;
                ctp = 2'($urandom_range(0, 3));
            end
            if (!spp && $urandom_range(0, 5) == 0) begin
                spp = 1'b1;
                swp = 16'($urandom);
            end
            gen_rx(rxw);
            step(cp, ctp, spp, swp, rxw);
            if (coin_acc) cp = 1'b0;
            if (sp_acc) spp = 1'b0;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
